ps2_keyboard: RTL and testbench
===============================

// Module: ps2_keyboard
// PURPOSE
//  Receive end of the PS/2 keyboard link: deserialises device-to-host frames, decodes make/break/E0
//  sequences and presents the Hack KBD register value (memory map 0x6000) to the CPU/memory system.
//  key holds the Hack code of the most recently pressed, still-held key; 0 when none is held.
// PARAMETERS
//  CLK_HZ       27_000_000  system clock frequency (Tang Primer 20K board clock)
//  TIMEOUT_US   2000        max gap between ps2_clk falling edges inside a frame before abort
//  SYNC_STAGES  2           flip-flop synchroniser depth on ps2_clk and ps2_data (>=2)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  ps2_clk    in   1   PS/2 clock from keyboard (asynchronous, open-collector, idle high)
//  ps2_data   in   1   PS/2 data from keyboard (asynchronous, idle high)
//  key        out  16  Hack keycode of held key, bits [15:8] always 0
//  key_valid  out  1   1-cycle pulse whenever key changes value
//  frame_err  out  1   1-cycle pulse on parity/stop error or timeout
// BEHAVIOUR
//  - Reset: key=0, key_valid=0, frame_err=0, FSM=IDLE, prefix flags cleared, sync FFs=1. Async assert
//    mid-frame discards the partial frame; no output pulse on release.
//  - Both inputs pass SYNC_STAGES FFs; a falling edge = synced ps2_clk 1->0; data sampled that cycle.
//  - Frame: start(0), 8 data LSB first, odd parity, stop(1). FSM IDLE->DATA(8 edges)->PARITY->STOP->IDLE.
//    IDLE leaves only when sampled start bit is 0; start=1 is ignored (stay IDLE, no error).
//  - STOP: stop=1 and parity odd -> byte accepted; else frame_err pulse, byte discarded, prefixes cleared.
//  - Timeout: TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US; counter reloads on every falling edge; expiry in
//    non-IDLE state -> IDLE, frame_err pulse, prefixes cleared. Counter idle in IDLE.
//  - Decoder on accepted byte b: E0 -> set ext; F0 -> set brk; else code = ps2_keymap({ext,b}), then
//    clear ext and brk. Make (brk=0): code!=0 and code!=key -> key<=code, key_valid pulse.
//    Break (brk=1): code==key and key!=0 -> key<=0, key_valid pulse. Otherwise no change, no pulse.
//  - Typematic repeats (same make while held) produce no pulse. Unmapped codes (0) ignored.
//  - Latency: key and key_valid update on the cycle after the stop bit is sampled; frame_err asserts
//    on the cycle after the stop sample or the timeout expiry. Never both pulses from one frame.
//  - Prefix E0 then F0 then scan (extended break) handled: both flags set before the scan byte.
//  - Host-to-device transmission is not supported; ps2_clk/ps2_data are never driven.
// STRUCTURE
//  - Shared include hack_kbd_defs.vh: Hack keycodes (NEWLINE 128, BACKSPACE 129, LEFT 130, UP 131,
//    RIGHT 132, DOWN 133, HOME 134, END 135, PGUP 136, PGDN 137, INSERT 138, DELETE 139, ESC 140,
//    F1..F12 141..152), PS/2 prefixes E0/F0, FSM state encodings.
//  - Sub-module ps2_keymap: combinational {ext,scan[7:0]} -> 8-bit Hack code, 0 = unmapped. Letters map
//    to uppercase ASCII 65..90, digits 48..57, space 32, plus the specials above.
//  - ps2_keyboard holds synchroniser, edge detect, frame FSM, timeout counter, prefix flags, key reg.
// TESTING  (bench drives ps2_clk at ~12.5 kHz, data changes on ps2_clk high)
//  1. rst_n low mid-frame (after 4 bits), release, send 0x1C -> key=0x0041, one key_valid, no frame_err.
//  2. 0x1C then F0 1C -> key 0x0041 then 0x0000, exactly two key_valid pulses total.
//  3. E0 75 -> key=131; E0 F0 75 -> key=0; plain 0x75 (keypad 8) -> no change unless mapped.
//  4. 0x1C with even parity -> frame_err pulse, key unchanged; then 0x29 -> key=32.
//  5. Start + 5 bits then silence -> frame_err after TIMEOUT_CYC cycles (+/-2), FSM IDLE; next 0x5A -> 128.
//  6. 1C,1C,1C -> one pulse; 1B -> key=83; F0 1C -> key stays 83, no pulse; F0 1B -> key=0.

Source files
------------

// File: rtl/ps2_keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// PS/2 prefix bytes, Hack special keycodes and a parity helper.
package ps2_keyboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;

    // A PS/2 frame is valid when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational translation of {extended flag, set-2 scan code} to a Hack
// keycode; 0 means the key has no Hack equivalent.
module ps2_keymap
    import ps2_keyboard_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] scan,
    output logic [7:0] code
);

    // Lookup table; extended and plain scan codes live in separate spaces.
    always_comb begin
        code = '0;
        if (!ext) begin
            case (scan)
                8'h1C: code = 8'd65;  8'h32: code = 8'd66;  8'h21: code = 8'd67;
                8'h23: code = 8'd68;  8'h24: code = 8'd69;  8'h2B: code = 8'd70;
                8'h34: code = 8'd71;  8'h33: code = 8'd72;  8'h43: code = 8'd73;
                8'h3B: code = 8'd74;  8'h42: code = 8'd75;  8'h4B: code = 8'd76;
                8'h3A: code = 8'd77;  8'h31: code = 8'd78;  8'h44: code = 8'd79;
                8'h4D: code = 8'd80;  8'h15: code = 8'd81;  8'h2D: code = 8'd82;
                8'h1B: code = 8'd83;  8'h2C: code = 8'd84;  8'h3C: code = 8'd85;
                8'h2A: code = 8'd86;  8'h1D: code = 8'd87;  8'h22: code = 8'd88;
                8'h35: code = 8'd89;  8'h1A: code = 8'd90;
                8'h45: code = 8'd48;  8'h16: code = 8'd49;  8'h1E: code = 8'd50;
                8'h26: code = 8'd51;  8'h25: code = 8'd52;  8'h2E: code = 8'd53;
                8'h36: code = 8'd54;  8'h3D: code = 8'd55;  8'h3E: code = 8'd56;
                8'h46: code = 8'd57;
                8'h29: code = 8'd32;
                8'h5A: code = KEY_NEWLINE;
                8'h66: code = KEY_BACKSPACE;
                8'h76: code = KEY_ESC;
                8'h05: code = KEY_F1;
                8'h06: code = KEY_F1 + 8'd1;
                8'h04: code = KEY_F1 + 8'd2;
                8'h0C: code = KEY_F1 + 8'd3;
                8'h03: code = KEY_F1 + 8'd4;
                8'h0B: code = KEY_F1 + 8'd5;
                8'h83: code = KEY_F1 + 8'd6;
                8'h0A: code = KEY_F1 + 8'd7;
                8'h01: code = KEY_F1 + 8'd8;
                8'h09: code = KEY_F1 + 8'd9;
                8'h78: code = KEY_F1 + 8'd10;
                8'h07: code = KEY_F1 + 8'd11;
                default: code = '0;
            endcase
        end else begin
            case (scan)
                8'h6B: code = KEY_LEFT;
                8'h75: code = KEY_UP;
                8'h74: code = KEY_RIGHT;
                8'h72: code = KEY_DOWN;
                8'h6C: code = KEY_HOME;
                8'h69: code = KEY_END;
                8'h7D: code = KEY_PGUP;
                8'h7A: code = KEY_PGDN;
                8'h70: code = KEY_INSERT;
                8'h71: code = KEY_DELETE;
                default: code = '0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises frames,
// decodes make/break/E0 sequences and holds the Hack KBD register value.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;
    logic                   fall;

    ps2_state_t             state;
    ps2_state_t             next_state;
    logic [7:0]             shift;
    logic [2:0]             bit_cnt;
    logic                   parity_bit;
    logic [CNT_W-1:0]       tmo_cnt;

    logic                   byte_done;
    logic                   frame_bad;
    logic                   timeout;

    logic                   ext_flag;
    logic                   brk_flag;
    logic [7:0]             key_code;
    logic [7:0]             map_code;

    assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
    assign ps2_data_s = data_sync[SYNC_STAGES-1];
    assign fall       = clk_prev & ~ps2_clk_s;
    assign key        = {8'h00, key_code};

    ps2_keymap u_keymap (
        .ext  (ext_flag),
        .scan (shift),
        .code (map_code)
    );

    // Bring both PS/2 lines into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= ps2_clk_s;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Frame FSM transitions, byte acceptance and error detection.
    always_comb begin
        next_state = state;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        timeout    = 1'b0;
        if (fall) begin
            case (state)
                ST_IDLE:   if (!ps2_data_s) next_state = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) next_state = ST_PARITY;
                ST_PARITY: next_state = ST_STOP;
                ST_STOP: begin
                    next_state = ST_IDLE;
                    if (ps2_data_s && odd_parity_ok(shift, parity_bit)) byte_done = 1'b1;
                    else                                               frame_bad = 1'b1;
                end
                default:   next_state = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && tmo_cnt == CNT_W'(1)) begin
            timeout    = 1'b1;
            next_state = ST_IDLE;
        end
    end

    // Shift register, bit counter, parity capture and inter-edge timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            if (fall) begin
                tmo_cnt <= CNT_W'(TIMEOUT_CYC);
                case (state)
                    ST_IDLE:   bit_cnt <= '0;
                    ST_DATA: begin
                        shift   <= {ps2_data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: parity_bit <= ps2_data_s;
                    default: ;
                endcase
            end else if (state != ST_IDLE && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - CNT_W'(1);
            end
        end
    end

    // Prefix tracking, held-key register and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_code  <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= frame_bad | timeout;
            if (frame_bad || timeout) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_done) begin
                if (shift == PS2_PREFIX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift == PS2_PREFIX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (!brk_flag) begin
                        if (map_code != '0 && map_code != key_code) begin
                            key_code  <= map_code;
                            key_valid <= 1'b1;
                        end
                    end else if (map_code == key_code && key_code != '0) begin
                        key_code  <= '0;
                        key_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus a randomised
// frame stream checked against a behavioural keyboard model.
module tb_ps2_keyboard;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned TIMEOUT_US  = 1000;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          TMO_CYC     = 1000;   // CLK_HZ/1e6 * TIMEOUT_US
    localparam int          CLK_PERIOD  = 1000;
    localparam int          HALF_BIT    = 40;     // 80-cycle PS/2 period ~ 12.5 kHz

    localparam logic [7:0] LETTER_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] FKEY_SC [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83,
        8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    localparam logic [7:0] NAV_SC [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D,
        8'h7A, 8'h70, 8'h71};
    localparam logic [7:0] POOL [10] = '{8'h1C, 8'h1B, 8'h29, 8'h5A, 8'h75, 8'h6B, 8'h76,
        8'h05, 8'h45, 8'h71};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        key_valid;
    logic        frame_err;

    int compared = 0;
    int mismatched = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    time t_last_fall = 0;

    // Reference model of the keyboard state.
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] m_key = 8'h00;
    int         exp_kv = 0;
    int         exp_fe = 0;

    ps2_keyboard #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #(150_000 * CLK_PERIOD);
        $display("FAIL watchdog: simulation exceeded 150000 cycles (compared %0d)", compared);
        $fatal(1);
    end

    function automatic logic [7:0] ref_map(input logic ext, input logic [7:0] sc);
        for (int i = 0; i < 26; i++) if (!ext && sc == LETTER_SC[i]) return 8'(65 + i);
        for (int i = 0; i < 10; i++) if (!ext && sc == DIGIT_SC[i])  return 8'(48 + i);
        for (int i = 0; i < 12; i++) if (!ext && sc == FKEY_SC[i])   return 8'(141 + i);
        for (int i = 0; i < 10; i++) if (ext && sc == NAV_SC[i])     return 8'(130 + i);
        if (!ext && sc == 8'h29) return 8'd32;
        if (!ext && sc == 8'h5A) return 8'd128;
        if (!ext && sc == 8'h66) return 8'd129;
        if (!ext && sc == 8'h76) return 8'd140;
        return 8'd0;
    endfunction

    function automatic void ref_frame(input logic [7:0] b, input logic good);
        logic [7:0] code;
        if (!good) begin
            m_ext = 1'b0; m_brk = 1'b0; exp_fe++;
            return;
        end
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            code = ref_map(m_ext, b);
            if (!m_brk) begin
                if (code != 8'd0 && code != m_key) begin m_key = code; exp_kv++; end
            end else if (code == m_key && m_key != 8'd0) begin
                m_key = 8'd0; exp_kv++;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endfunction

    task automatic send_bits(input logic [7:0] b, input logic bad, input int nbits, output int lat);
        logic [10:0] fr;
        fr  = {1'b1, (~^b) ^ bad, b, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF_BIT / 2) @(negedge clk);
            ps2_data = fr[i];
            repeat (HALF_BIT / 2) @(negedge clk);
            ps2_clk = 1'b0;
            t_last_fall = $time;
            for (int c = 1; c <= HALF_BIT; c++) begin
                @(negedge clk); #1;
                if (i == nbits - 1 && lat < 0 && (key_valid === 1'b1 || frame_err === 1'b1)) lat = c;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF_BIT) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        int lat;
        send_bits(b, bad, 11, lat);
        ref_frame(b, !bad);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_key = 8'h00;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int kv0, fe0, lat;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        compared++; if (key !== 16'h0000) begin mismatched++; $display("FAIL reset_key: got %h want 0000", key); end
        compared++; if (key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_bits(8'h1C, 1'b0, 4, lat);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        kv0 = kv_cnt; fe0 = fe_cnt;
        rst_n = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_key = 8'h00;
        repeat (10) @(negedge clk);
        #1;
        compared++; if (kv_cnt !== kv0 || fe_cnt !== fe0) begin
            mismatched++; $display("FAIL reset_release_pulse: kv %0d fe %0d want kv %0d fe %0d", kv_cnt, fe_cnt, kv0, fe0);
        end
        send_byte(8'h1C, 1'b0);
        compared++; if (key !== 16'h0041) begin mismatched++; $display("FAIL reset_then_A: got %h want 0041", key); end
        compared++; if (kv_cnt - kv0 !== 1) begin mismatched++; $display("FAIL reset_then_A_kv: got %0d want 1", kv_cnt - kv0); end
        compared++; if (fe_cnt - fe0 !== 0) begin mismatched++; $display("FAIL reset_then_A_fe: got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_make_break();
        int kv0, lat;
        reset_dut();
        kv0 = kv_cnt;
        send_bits(8'h1C, 1'b0, 11, lat);
        ref_frame(8'h1C, 1'b1);
        compared++; if (key !== 16'h0041) begin mismatched++; $display("FAIL make_A: got %h want 0041", key); end
        compared++; if (lat < int'(SYNC_STAGES) || lat > int'(SYNC_STAGES) + 2) begin
            mismatched++; $display("FAIL make_latency: got %0d want %0d..%0d", lat, SYNC_STAGES, SYNC_STAGES + 2);
        end
        send_byte(8'hF0, 1'b0);
        compared++; if (key !== 16'h0041) begin mismatched++; $display("FAIL break_prefix_only: got %h want 0041", key); end
        send_byte(8'h1C, 1'b0);
        compared++; if (key !== 16'h0000) begin mismatched++; $display("FAIL break_A: got %h want 0000", key); end
        compared++; if (kv_cnt - kv0 !== 2) begin mismatched++; $display("FAIL make_break_kv: got %0d want 2", kv_cnt - kv0); end
    endtask

    task automatic test_extended();
        int kv0;
        reset_dut();
        kv0 = kv_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        compared++; if (key !== 16'd131) begin mismatched++; $display("FAIL ext_up: got %0d want 131", key); end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        compared++; if (key !== 16'd0) begin mismatched++; $display("FAIL ext_break_up: got %0d want 0", key); end
        send_byte(8'h75, 1'b0);
        compared++; if (key !== 16'd0) begin mismatched++; $display("FAIL keypad8_unmapped: got %0d want 0", key); end
        send_byte(8'hE0, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h75, 1'b0);
        compared++; if (key !== 16'd0) begin mismatched++; $display("FAIL prefix_cleared_by_err: got %0d want 0", key); end
        compared++; if (kv_cnt - kv0 !== 2) begin mismatched++; $display("FAIL ext_kv: got %0d want 2", kv_cnt - kv0); end
    endtask

    task automatic test_parity();
        int kv0, fe0, lat;
        reset_dut();
        kv0 = kv_cnt; fe0 = fe_cnt;
        send_bits(8'h1C, 1'b1, 11, lat);
        ref_frame(8'h1C, 1'b0);
        compared++; if (fe_cnt - fe0 !== 1) begin mismatched++; $display("FAIL parity_fe: got %0d want 1", fe_cnt - fe0); end
        compared++; if (kv_cnt - kv0 !== 0) begin mismatched++; $display("FAIL parity_kv: got %0d want 0", kv_cnt - kv0); end
        compared++; if (key !== 16'd0) begin mismatched++; $display("FAIL parity_key: got %0d want 0", key); end
        compared++; if (lat < int'(SYNC_STAGES) || lat > int'(SYNC_STAGES) + 2) begin
            mismatched++; $display("FAIL parity_fe_latency: got %0d want %0d..%0d", lat, SYNC_STAGES, SYNC_STAGES + 2);
        end
        send_byte(8'h29, 1'b0);
        compared++; if (key !== 16'd32) begin mismatched++; $display("FAIL space_after_err: got %0d want 32", key); end
        compared++; if (fe_cnt - fe0 !== 1) begin mismatched++; $display("FAIL space_fe: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_timeout();
        int kv0, fe0, lat, elapsed;
        logic seen;
        reset_dut();
        kv0 = kv_cnt; fe0 = fe_cnt;
        seen = 1'b0; elapsed = -1;
        send_bits(8'hA5, 1'b0, 6, lat);
        for (int c = 0; c < TMO_CYC + 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (frame_err === 1'b1) begin
                seen = 1'b1;
                elapsed = int'(($time - t_last_fall) / CLK_PERIOD);
            end
        end
        m_ext = 1'b0; m_brk = 1'b0; exp_fe++;
        compared++; if (!seen) begin mismatched++; $display("FAIL timeout_seen: got none want pulse within %0d cycles", TMO_CYC + 100); end
        // Window includes the synchroniser and edge-detect delay after the line falls.
        compared++; if (elapsed < TMO_CYC - 2 || elapsed > TMO_CYC + int'(SYNC_STAGES) + 3) begin
            mismatched++; $display("FAIL timeout_cycles: got %0d want %0d..%0d", elapsed, TMO_CYC - 2, TMO_CYC + SYNC_STAGES + 3);
        end
        repeat (5) @(negedge clk);
        #1;
        compared++; if (fe_cnt - fe0 !== 1) begin mismatched++; $display("FAIL timeout_fe_count: got %0d want 1", fe_cnt - fe0); end
        compared++; if (kv_cnt - kv0 !== 0) begin mismatched++; $display("FAIL timeout_kv: got %0d want 0", kv_cnt - kv0); end
        send_byte(8'h5A, 1'b0);
        compared++; if (key !== 16'd128) begin mismatched++; $display("FAIL enter_after_timeout: got %0d want 128", key); end
    endtask

    task automatic test_typematic();
        int kv0;
        reset_dut();
        kv0 = kv_cnt;
        repeat (3) send_byte(8'h1C, 1'b0);
        compared++; if (key !== 16'd65) begin mismatched++; $display("FAIL repeat_key: got %0d want 65", key); end
        compared++; if (kv_cnt - kv0 !== 1) begin mismatched++; $display("FAIL repeat_kv: got %0d want 1", kv_cnt - kv0); end
        send_byte(8'h1B, 1'b0);
        compared++; if (key !== 16'd83) begin mismatched++; $display("FAIL second_key: got %0d want 83", key); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        compared++; if (key !== 16'd83) begin mismatched++; $display("FAIL stale_break: got %0d want 83", key); end
        compared++; if (kv_cnt - kv0 !== 2) begin mismatched++; $display("FAIL stale_break_kv: got %0d want 2", kv_cnt - kv0); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1B, 1'b0);
        compared++; if (key !== 16'd0) begin mismatched++; $display("FAIL release_S: got %0d want 0", key); end
        compared++; if (kv_cnt - kv0 !== 3) begin mismatched++; $display("FAIL release_S_kv: got %0d want 3", kv_cnt - kv0); end
    endtask

    task automatic test_random();
        logic [7:0] b, last_scan;
        logic bad;
        int r;
        reset_dut();
        exp_kv = kv_cnt; exp_fe = fe_cnt;   // model totals start from the current pulse tallies
        last_scan = 8'h1C;
        for (int n = 0; n < 28; n++) begin
            r = int'($urandom_range(0, 9));
            bad = 1'b0;
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4, 5:    b = last_scan;
                9: begin b = 8'($urandom_range(0, 255)); bad = 1'b1; end
                default: b = POOL[$urandom_range(0, 9)];
            endcase
            if (b != 8'hE0 && b != 8'hF0 && !bad) last_scan = b;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_byte(b, bad);
            compared++; if (key !== {8'h00, m_key}) begin
                mismatched++; $display("FAIL rand_key[%0d] byte %h: got %0d want %0d", n, b, key, m_key);
            end
            compared++; if (kv_cnt !== exp_kv) begin
                mismatched++; $display("FAIL rand_kv[%0d] byte %h: got %0d want %0d", n, b, kv_cnt, exp_kv);
            end
            compared++; if (fe_cnt !== exp_fe) begin
                mismatched++; $display("FAIL rand_fe[%0d] byte %h: got %0d want %0d", n, b, fe_cnt, exp_fe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_parity();
        test_timeout();
        test_typematic();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
